// File: rtl/fb_pkg.sv
// Shared FREEDM bus nibble-link definitions: line symbols, CRC-8 constants and the TX framer state type.
package fb_pkg;

  localparam logic [3:0] FB_PREAMBLE = 4'h5;
  localparam logic [3:0] FB_SFD      = 4'hD;
  localparam logic [7:0] FB_CRC_INIT = 8'hFF;
  localparam logic [7:0] FB_CRC_POLY = 8'hA7;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SFD,
    D_HI,
    D_LO,
    C_HI,
    C_LO,
    IFG
  } tx_state_t;

  // One nibble through the CRC, Data[3] first, MSB-first shift register.
  function automatic logic [7:0] fb_crc8_nibble(input logic [7:0] crc, input logic [3:0] data);
    logic [7:0] c;
    c = crc;
    for (int i = 3; i >= 0; i--) begin
      if (c[7] ^ data[i]) c = {c[6:0], 1'b0} ^ FB_CRC_POLY;
      else                c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/fb_tx_crc8.sv
// Registered CRC-8 (poly 0xA7, init 0xFF), one nibble per enabled cycle; Initialize wins over Enable.
// Crc reflects all nibbles enabled up to the previous clock edge; no backpressure.
module fb_tx_crc8
  import fb_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] Data,
  input  logic       Enable,
  input  logic       Initialize,
  output logic [7:0] Crc
);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)           Crc <= FB_CRC_INIT;
    else if (Initialize) Crc <= FB_CRC_INIT;
    else if (Enable)     Crc <= fb_crc8_nibble(Crc, Data);
  end

endmodule

// File: rtl/fb_tx_framer.sv
// Nibble-link TX framer: preamble, SFD, payload, ~CRC-8, then forced IFG; first nibble 1 cycle after TxValid, 1 byte per 2 cycles.
// TxReady only in SFD/D_LO; a starved source aborts the frame with a corrupted CRC. FB_TX_PAD_EN pads short frames with 8'h00.
module fb_tx_framer
  import fb_pkg::*;
#(
  parameter int PREAMBLE_NIBBLES = 7,
  parameter int IFG_CYCLES       = 12
`ifdef FB_TX_PAD_EN
  , parameter int MIN_PAYLOAD    = 4
`endif
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] TxData,
  input  logic       TxValid,
  input  logic       TxLast,
  output logic       TxReady,
  output logic [3:0] TxNibble,
  output logic       TxEn,
  output logic       TxBusy,
  output logic       TxDone,
  output logic       TxUnderrun
);

  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_NIBBLES - 1);
  localparam logic [7:0] IFG_LAST = 8'(IFG_CYCLES - 1);

  tx_state_t  state, state_nxt;
  logic [7:0] cyc_cnt;
  logic [7:0] byte_r;
  logic       last_r;
  logic       und_r;
  logic       pad_r;
  logic       hs;
  logic       crc_en, crc_init;
  logic [7:0] crc;
  logic [7:0] crc_tx;

  assign hs     = TxValid & TxReady;
  assign crc_tx = ~crc ^ {7'd0, und_r};

  fb_tx_crc8 u_crc (
    .Clk        (Clk),
    .Reset      (Reset),
    .Data       (TxNibble),
    .Enable     (crc_en),
    .Initialize (crc_init),
    .Crc        (crc)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    TxNibble   = 4'h0;
    TxEn       = 1'b0;
    TxBusy     = (state != IDLE);
    TxReady    = 1'b0;
    TxDone     = 1'b0;
    TxUnderrun = 1'b0;
    crc_en     = 1'b0;
    crc_init   = 1'b0;
    case (state)
      IDLE: begin
        if (TxValid) state_nxt = PRE;
      end
      PRE: begin
        TxEn     = 1'b1;
        TxNibble = FB_PREAMBLE;
        if (cyc_cnt == PRE_LAST) state_nxt = SFD;
      end
      SFD: begin
        // A source that has already dropped valid is treated as starved.
        TxEn     = 1'b1;
        TxNibble = FB_SFD;
        TxReady  = 1'b1;
        crc_init = 1'b1;
        if (TxValid) begin
          state_nxt = D_HI;
        end else begin
          TxUnderrun = 1'b1;
          state_nxt  = C_HI;
        end
      end
      D_HI: begin
        TxEn      = 1'b1;
        TxNibble  = byte_r[7:4];
        crc_en    = 1'b1;
        state_nxt = D_LO;
      end
      D_LO: begin
        TxEn     = 1'b1;
        TxNibble = byte_r[3:0];
        crc_en   = 1'b1;
        TxReady  = !last_r && !pad_r;
        if (last_r) begin
          state_nxt = C_HI;
        end else if (pad_r || TxValid) begin
          state_nxt = D_HI;
        end else begin
          TxUnderrun = 1'b1;
          state_nxt  = C_HI;
        end
      end
      C_HI: begin
        TxEn      = 1'b1;
        TxNibble  = crc_tx[7:4];
        state_nxt = C_LO;
      end
      C_LO: begin
        TxEn      = 1'b1;
        TxNibble  = crc_tx[3:0];
        TxDone    = 1'b1;
        state_nxt = IFG;
      end
      IFG: begin
        // Skipping IDLE here lets a waiting source start right after the last gap cycle.
        if (cyc_cnt == IFG_LAST) state_nxt = TxValid ? PRE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef FB_TX_PAD_EN
  localparam logic [7:0] MIN_LEN = 8'(MIN_PAYLOAD);
  logic [7:0] pay_cnt;
  logic [7:0] pay_inc;

  assign pay_inc = (pay_cnt == 8'hFF) ? pay_cnt : pay_cnt + 8'd1;
`else
  assign pad_r = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cyc_cnt <= 8'd0;
      byte_r  <= 8'd0;
      last_r  <= 1'b0;
      und_r   <= 1'b0;
`ifdef FB_TX_PAD_EN
      pad_r   <= 1'b0;
      pay_cnt <= 8'd0;
`endif
    end else begin
      cyc_cnt <= (state != state_nxt) ? 8'd0 : cyc_cnt + 8'd1;
      if (state == PRE) begin
        last_r <= 1'b0;
        und_r  <= 1'b0;
`ifdef FB_TX_PAD_EN
        pad_r   <= 1'b0;
        pay_cnt <= 8'd0;
`endif
      end
      if (TxUnderrun) und_r <= 1'b1;
`ifdef FB_TX_PAD_EN
      if (hs) begin
        byte_r  <= TxData;
        pay_cnt <= pay_inc;
        if (TxLast && (pay_inc < MIN_LEN)) begin
          pad_r  <= 1'b1;
          last_r <= 1'b0;
        end else begin
          last_r <= TxLast;
        end
      end else if (state == D_LO && pad_r && !last_r) begin
        byte_r  <= 8'h00;
        pay_cnt <= pay_inc;
        last_r  <= (pay_inc >= MIN_LEN);
      end
`else
      if (hs) begin
        byte_r <= TxData;
        last_r <= TxLast;
      end
`endif
    end
  end

endmodule
